camera_param_bank: RTL and testbench
====================================

# camera_param_bank

Double-buffered, frame-synchronous parameter register bank for the raymarching camera. It generalises the fixed eye/lookat PIO exports to NUM_REGS words of DATA_W bits. The HPS-side bus master writes a shadow copy at any time; the whole set is copied atomically into the active copy, either on the next frame boundary or immediately, depending on mode. The active copy drives the raymarcher, so a frame never renders with a half-updated camera (mixed old/new eye or lookat values).

## Interface
- NUM_REGS, 12: number of parameter words (default covers eye x/y/z plus the 3x3 lookat matrix).
- DATA_W, 32: width of each word.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= NUM_REGS.
- EPOCH_W, 8: width of the commit epoch counter.
- SYNC_MODE, 1: 1 = commit applies on frame_start; 0 = commit applies on the edge where commit_req is sampled.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  ADDR_W  shadow word index.
- wr_data  in  DATA_W  shadow write data.
- commit_req  in  1  single-cycle request to publish the shadow set.
- frame_start  in  1  single-cycle pulse from the VGA/raymarch timing, marking the frame boundary.
- rd_addr  in  ADDR_W  readback index.
- rd_sel  in  1  readback source: 0 = shadow, 1 = active.
- rd_data  out  DATA_W  registered readback data.
- param_out  out  NUM_REGS*DATA_W  active words; word i occupies bits [i*DATA_W +: DATA_W].
- commit_pending  out  1  request armed, not yet applied.
- commit_ack  out  1  one-cycle pulse on each apply.
- epoch  out  EPOCH_W  count of applies.
- wr_err  out  1  sticky: set by a write to an out-of-range address.

## Operation
- Reset: all shadow and active words = 0; param_out = 0; rd_data = 0; commit_pending = 0; commit_ack = 0; epoch = 0; wr_err = 0. Reset overrides every other input in the same cycle.
- Writes: when wr_en=1 and wr_addr < NUM_REGS, the shadow word is updated. When wr_addr >= NUM_REGS, no storage changes and wr_err is set; wr_err clears only on reset. Writes never touch the active copy directly.
- Control FSM has two states: IDLE (commit_pending=0) and ARMED (commit_pending=1).
- SYNC_MODE=1:
  - apply = frame_start & (commit_pending | commit_req).
  - IDLE -> ARMED when commit_req=1 and apply=0.
  - Any state -> IDLE when apply=1.
  - A commit_req while ARMED is absorbed; only one apply results.
- SYNC_MODE=0:
  - apply = commit_req; frame_start is ignored.
  - commit_pending is held at 0.
- Apply edge:
  - Active copy takes the shadow contents as they stood before that edge.
  - A write occurring on the same edge lands in the shadow only and reaches the active copy on the next apply.
  - commit_ack = 1 for the following cycle.
  - epoch increments by 1, wrapping modulo 2^EPOCH_W.
- Readback: rd_data is registered from the selected copy at rd_addr. An out-of-range rd_addr returns 0. Readback has no side effects.

## Timing
- Write latency: a shadow write on edge N is visible via readback (rd_sel=0) when rd_data is sampled at edge N+1. Same-address write and read in one cycle returns the old value.
- Apply latency: param_out, epoch and commit_ack change together, one cycle after the apply edge (registered). No combinational path from any input to param_out.
- SYNC_MODE=1 worst case: the commit waits one full frame.
- Frame boundaries without a pending commit leave all outputs unchanged.
- Reset asserted while ARMED: the pending request is discarded and the active copy returns to 0.

## Test plan
- Reset, then write words 0..11 with values 0x100+i, with no commit → param_out stays 0 and readback with rd_sel=0 returns 0x10B at addr 11.
- SYNC_MODE=1: commit_req, then frame_start 10 cycles later → commit_pending is high for 10 cycles; word 5 of param_out = 0x105 one cycle after frame_start; commit_ack pulses once; epoch = 1.
- SYNC_MODE=1: commit_req and frame_start in the same cycle, with a write of 0xDEAD to addr 0 on that edge → active word 0 keeps its pre-write value; readback with rd_sel=0 at addr 0 returns 0xDEAD; epoch increments.
- Two commit_req pulses before one frame_start → exactly one commit_ack, epoch +1; a second frame_start with no request leaves everything unchanged.
- Write to addr 14 with NUM_REGS=12 → no word changes, wr_err = 1 and stays set until reset. Readback at addr 14 returns 0.
- SYNC_MODE=0 with EPOCH_W=2: five commit_req pulses → epoch sequence 1, 2, 3, 0, 1. Assert reset while ARMED (SYNC_MODE=1) → commit_pending = 0, param_out = 0.

Source files
------------

// File: rtl/camera_param_bank.sv
// camera_param_bank: double-buffered camera parameter registers.
// The bus side writes a shadow set at any time; the whole set is published
// atomically into the active set, either on the next frame boundary
// (SYNC_MODE=1) or on the edge that samples commit_req (SYNC_MODE=0).
module camera_param_bank #(
  parameter int NUM_REGS  = 12,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int EPOCH_W   = 8,
  parameter int SYNC_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       commit_req,
  input  logic                       frame_start,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_sel,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_REGS*DATA_W-1:0] param_out,
  output logic                       commit_pending,
  output logic                       commit_ack,
  output logic [EPOCH_W-1:0]         epoch,
  output logic                       wr_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];
  logic              wr_in_range;
  logic              rd_in_range;
  logic              apply;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range = int'(wr_addr) < NUM_REGS;
  assign rd_in_range = int'(rd_addr) < NUM_REGS;

  // In frame-sync mode an armed request (or one arriving this cycle) fires on
  // the frame boundary; otherwise the request itself is the apply strobe.
  assign apply = (SYNC_MODE != 0)
               ? (frame_start & ((state == ST_ARMED) | commit_req))
               : commit_req;

  assign commit_pending = (state == ST_ARMED);

  // Shadow set: bus writes land here only, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (wr_en && wr_in_range) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Active set: takes the pre-edge shadow contents, so a write on the apply
  // edge waits for the next apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) active[i] <= '0;
    end else if (apply) begin
      active <= shadow;
    end
  end

  // Commit control: IDLE/ARMED state, ack pulse, epoch counter, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      commit_ack <= 1'b0;
      epoch      <= '0;
      wr_err     <= 1'b0;
    end else begin
      commit_ack <= apply;
      if (apply) epoch <= epoch + 1'b1;
      if (wr_en && !wr_in_range) wr_err <= 1'b1;
      if (SYNC_MODE == 0 || apply) state <= ST_IDLE;
      else if (commit_req)         state <= ST_ARMED;
    end
  end

  // Readback source mux; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = rd_sel ? active[rd_addr] : shadow[rd_addr];
  end

  // Registered readback.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_word;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
    assign param_out[i*DATA_W +: DATA_W] = active[i];
  end

endmodule

// File: tb/tb_camera_param_bank.sv
// Directed bench for camera_param_bank: one frame-sync instance with default
// parameters and one immediate-mode instance with a 2-bit epoch.
module tb_camera_param_bank;

  localparam int NR = 12;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // frame-sync instance
  logic            wr_en, commit_req, frame_start, rd_sel;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [DW-1:0]   wr_data, rd_data;
  logic [NR*DW-1:0] param_out;
  logic            commit_pending, commit_ack, wr_err;
  logic [7:0]      epoch;

  // immediate-mode instance
  logic            wr_en0, commit_req0, frame_start0, rd_sel0;
  logic [AW-1:0]   wr_addr0, rd_addr0;
  logic [DW-1:0]   wr_data0, rd_data0;
  logic [NR*DW-1:0] param_out0;
  logic            commit_pending0, commit_ack0, wr_err0;
  logic [1:0]      epoch0;

  camera_param_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .EPOCH_W(8), .SYNC_MODE(1)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .frame_start(frame_start), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .rd_data(rd_data), .param_out(param_out), .commit_pending(commit_pending),
    .commit_ack(commit_ack), .epoch(epoch), .wr_err(wr_err));

  camera_param_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .EPOCH_W(2), .SYNC_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .commit_req(commit_req0), .frame_start(frame_start0), .rd_addr(rd_addr0), .rd_sel(rd_sel0),
    .rd_data(rd_data0), .param_out(param_out0), .commit_pending(commit_pending0),
    .commit_ack(commit_ack0), .epoch(epoch0), .wr_err(wr_err0));

  int vectors = 0;
  int errors  = 0;

  // Expected active words of the frame-sync instance.
  logic [DW-1:0] exp_act [NR];

  function automatic logic [NR*DW-1:0] pack_act();
    logic [NR*DW-1:0] p;
    for (int i = 0; i < NR; i++) p[i*DW +: DW] = exp_act[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++; if (param_out !== '0) begin errors++; $display("FAIL reset_param_out got %h want 0", param_out); end
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    vectors++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", commit_pending); end
    vectors++; if (commit_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", commit_ack); end
    vectors++; if (epoch !== 8'd0) begin errors++; $display("FAIL reset_epoch got %0d want 0", epoch); end
    vectors++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    vectors++; if (epoch0 !== 2'd0) begin errors++; $display("FAIL reset_epoch0 got %0d want 0", epoch0); end
  endtask

  task automatic test_shadow_write();
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h100 + i;
      tick();
    end
    wr_en = 1'b0;
    rd_sel = 1'b0; rd_addr = 4'd11;
    tick();
    vectors++; if (rd_data !== 32'h10B) begin errors++; $display("FAIL shadow_rd11 got %h want 0000010b", rd_data); end
    vectors++; if (param_out !== '0) begin errors++; $display("FAIL shadow_no_commit got %h want 0", param_out); end
    // same-address write and read in one cycle returns the old word
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h333; rd_addr = 4'd3;
    tick();
    vectors++; if (rd_data !== 32'h103) begin errors++; $display("FAIL rd_during_wr got %h want 00000103", rd_data); end
    wr_data = 32'h103;
    tick();
    wr_en = 1'b0;
    vectors++; if (rd_data !== 32'h333) begin errors++; $display("FAIL rd_after_wr got %h want 00000333", rd_data); end
    tick();
    vectors++; if (rd_data !== 32'h103) begin errors++; $display("FAIL rd_restore got %h want 00000103", rd_data); end
  endtask

  task automatic test_sync_commit();
    int pend_cycles = 0;
    int acks = 0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    if (commit_pending === 1'b1) pend_cycles++;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (commit_pending === 1'b1) pend_cycles++;
      if (commit_ack === 1'b1) acks++;
    end
    vectors++; if (param_out !== '0) begin errors++; $display("FAIL sync_early_apply got %h want 0", param_out); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < NR; i++) exp_act[i] = 32'h100 + i;
    vectors++; if (pend_cycles != 10) begin errors++; $display("FAIL sync_pending_cycles got %0d want 10", pend_cycles); end
    vectors++; if (param_out[5*DW +: DW] !== 32'h105) begin errors++; $display("FAIL sync_word5 got %h want 00000105", param_out[5*DW +: DW]); end
    vectors++; if (param_out !== pack_act()) begin errors++; $display("FAIL sync_all_words got %h want %h", param_out, pack_act()); end
    vectors++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL sync_pending_clr got %b want 0", commit_pending); end
    vectors++; if (epoch !== 8'd1) begin errors++; $display("FAIL sync_epoch got %0d want 1", epoch); end
    if (commit_ack === 1'b1) acks++;
    rd_sel = 1'b1; rd_addr = 4'd5;
    tick();
    if (commit_ack === 1'b1) acks++;
    vectors++; if (acks != 1) begin errors++; $display("FAIL sync_ack_count got %0d want 1", acks); end
    vectors++; if (rd_data !== 32'h105) begin errors++; $display("FAIL sync_rd_active got %h want 00000105", rd_data); end
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD;
    commit_req = 1'b1; frame_start = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0; frame_start = 1'b0;
    vectors++; if (param_out[DW-1:0] !== 32'h100) begin errors++; $display("FAIL same_edge_active0 got %h want 00000100", param_out[DW-1:0]); end
    vectors++; if (epoch !== 8'd2) begin errors++; $display("FAIL same_edge_epoch got %0d want 2", epoch); end
    vectors++; if (commit_ack !== 1'b1) begin errors++; $display("FAIL same_edge_ack got %b want 1", commit_ack); end
    vectors++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL same_edge_pending got %b want 0", commit_pending); end
    rd_sel = 1'b0; rd_addr = 4'd0;
    tick();
    vectors++; if (rd_data !== 32'hDEAD) begin errors++; $display("FAIL same_edge_shadow got %h want 0000dead", rd_data); end
    rd_sel = 1'b1;
    tick();
    vectors++; if (rd_data !== 32'h100) begin errors++; $display("FAIL same_edge_rd_active got %h want 00000100", rd_data); end
  endtask

  task automatic test_double_req();
    int acks = 0;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    if (commit_ack === 1'b1) acks++;
    tick();
    if (commit_ack === 1'b1) acks++;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    if (commit_ack === 1'b1) acks++;
    vectors++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL dbl_pending got %b want 1", commit_pending); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    if (commit_ack === 1'b1) acks++;
    exp_act[0] = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (commit_ack === 1'b1) acks++;
    end
    vectors++; if (acks != 1) begin errors++; $display("FAIL dbl_ack_count got %0d want 1", acks); end
    vectors++; if (epoch !== 8'd3) begin errors++; $display("FAIL dbl_epoch got %0d want 3", epoch); end
    vectors++; if (param_out !== pack_act()) begin errors++; $display("FAIL dbl_words got %h want %h", param_out, pack_act()); end
    // a frame boundary with nothing pending changes nothing
    acks = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    if (commit_ack === 1'b1) acks++;
    tick();
    if (commit_ack === 1'b1) acks++;
    vectors++; if (acks != 0) begin errors++; $display("FAIL idle_frame_ack got %0d want 0", acks); end
    vectors++; if (epoch !== 8'd3) begin errors++; $display("FAIL idle_frame_epoch got %0d want 3", epoch); end
    vectors++; if (param_out !== pack_act()) begin errors++; $display("FAIL idle_frame_words got %h want %h", param_out, pack_act()); end
  endtask

  task automatic test_wr_err();
    logic [DW-1:0] exp_sh [NR];
    for (int i = 0; i < NR; i++) exp_sh[i] = 32'h100 + i;
    exp_sh[0] = 32'hDEAD;
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'hBAD;
    tick();
    wr_en = 1'b0;
    vectors++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set got %b want 1", wr_err); end
    vectors++; if (param_out !== pack_act()) begin errors++; $display("FAIL wr_err_active got %h want %h", param_out, pack_act()); end
    rd_sel = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd_addr = AW'(i);
      tick();
      vectors++;
      if (rd_data !== exp_sh[i]) begin errors++; $display("FAIL wr_err_shadow[%0d] got %h want %h", i, rd_data, exp_sh[i]); end
    end
    rd_addr = 4'd14;
    tick();
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL rd_oor_shadow got %h want 0", rd_data); end
    rd_sel = 1'b1;
    tick();
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL rd_oor_active got %h want 0", rd_data); end
    vectors++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_sticky got %b want 1", wr_err); end
  endtask

  task automatic test_immediate_mode();
    logic [1:0] exp_ep [5];
    exp_ep[0] = 2'd1; exp_ep[1] = 2'd2; exp_ep[2] = 2'd3; exp_ep[3] = 2'd0; exp_ep[4] = 2'd1;
    wr_en0 = 1'b1; wr_addr0 = 4'd2; wr_data0 = 32'hAB;
    tick();
    wr_en0 = 1'b0;
    frame_start0 = 1'b1; tick(); frame_start0 = 1'b0;
    vectors++; if (epoch0 !== 2'd0) begin errors++; $display("FAIL imm_frame_ignored got %0d want 0", epoch0); end
    for (int k = 0; k < 5; k++) begin
      commit_req0 = 1'b1; tick(); commit_req0 = 1'b0;
      vectors++; if (epoch0 !== exp_ep[k]) begin errors++; $display("FAIL imm_epoch[%0d] got %0d want %0d", k, epoch0, exp_ep[k]); end
      vectors++; if (commit_ack0 !== 1'b1) begin errors++; $display("FAIL imm_ack[%0d] got %b want 1", k, commit_ack0); end
      vectors++; if (commit_pending0 !== 1'b0) begin errors++; $display("FAIL imm_pending[%0d] got %b want 0", k, commit_pending0); end
      tick();
      vectors++; if (commit_ack0 !== 1'b0) begin errors++; $display("FAIL imm_ack_drop[%0d] got %b want 0", k, commit_ack0); end
    end
    vectors++; if (param_out0[2*DW +: DW] !== 32'hAB) begin errors++; $display("FAIL imm_word2 got %h want 000000ab", param_out0[2*DW +: DW]); end
  endtask

  task automatic test_reset_armed();
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    vectors++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL armed_before_reset got %b want 1", commit_pending); end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL armed_reset_pending got %b want 0", commit_pending); end
    vectors++; if (param_out !== '0) begin errors++; $display("FAIL armed_reset_words got %h want 0", param_out); end
    vectors++; if (wr_err !== 1'b0) begin errors++; $display("FAIL armed_reset_wr_err got %b want 0", wr_err); end
    vectors++; if (epoch !== 8'd0) begin errors++; $display("FAIL armed_reset_epoch got %0d want 0", epoch); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    vectors++; if (commit_ack !== 1'b0) begin errors++; $display("FAIL armed_discard_ack got %b want 0", commit_ack); end
    vectors++; if (epoch !== 8'd0) begin errors++; $display("FAIL armed_discard_epoch got %0d want 0", epoch); end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit_req = 1'b0; frame_start = 1'b0;
    rd_addr = '0; rd_sel = 1'b0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; commit_req0 = 1'b0; frame_start0 = 1'b0;
    rd_addr0 = '0; rd_sel0 = 1'b0;
    for (int i = 0; i < NR; i++) exp_act[i] = '0;
    test_reset();
    test_shadow_write();
    test_sync_commit();
    test_same_edge();
    test_double_req();
    test_wr_err();
    test_immediate_mode();
    test_reset_armed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
